// File: rtl/spectro_readout_if.sv
// Bundle of readout-sequencer signals: acquisition events and serial back-pressure
// going in, RAM read address/enable and shift-register controls coming out.
// Modports: master = sequencer side, slave = acquisition memory / serial sink side.
interface spectro_readout_if #(
  parameter int NBANK  = 2,
  parameter int DEPTH  = 200,
  parameter int FCNT_W = 16
);
  localparam int BW = $clog2(NBANK);
  localparam int AW = $clog2(DEPTH);

  logic              bank_full;
  logic              mem_done;
  logic [AW-1:0]     last_idx;
  logic              ser_stall;
  logic [BW+AW-1:0]  addr_out;
  logic              re;
  logic              SL_time;
  logic              SL_ch;
  logic              selection_bit;
  logic              serial_readout;
  logic              sending_data;
  logic              overflow;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    input  bank_full, mem_done, last_idx, ser_stall,
    output addr_out, re, SL_time, SL_ch, selection_bit, serial_readout,
           sending_data, overflow, frame_cnt
  );

  modport slave (
    output bank_full, mem_done, last_idx, ser_stall,
    input  addr_out, re, SL_time, SL_ch, selection_bit, serial_readout,
           sending_data, overflow, frame_cnt
  );
endinterface

// File: rtl/spectro_readout_seq.sv
// Purpose: per event, shifts out the timestamp then every queued channel bank word by word
//          (full banks over the whole depth, the closing partial bank up to its last index).
// Latency: event start 1 cycle after a bank is queued; re leads each SL_ch by one cycle (1-cycle RAM).
// Backpressure: ser_stall freezes state, counters and address; loads/shifts/re are gated off that cycle.
// Ports: clk, reset (async, active-high), bus (spectro_readout_if.master).
module spectro_readout_seq #(
  parameter int NBANK      = 2,
  parameter int DEPTH      = 200,
  parameter int TS_W       = 30,
  parameter int WORD_SHIFT = 2,
  parameter int FCNT_W     = 16
) (
  input logic              clk,
  input logic              reset,
  spectro_readout_if.master bus
);
  localparam int BW    = $clog2(NBANK);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(NBANK + 1);
  localparam int MAXSH = (TS_W > WORD_SHIFT) ? TS_W : WORD_SHIFT;
  localparam int CW    = $clog2(MAXSH) + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] TS_LAST   = CW'(TS_W - 1);
  localparam logic [CW-1:0] WS_LAST   = CW'(WORD_SHIFT - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(NBANK);
  localparam logic [BW-1:0] BANK_LAST = BW'(NBANK - 1);

  typedef enum logic [2:0] {IDLE, TS_LD, TS_SH, BANK_SEL, W_LD, W_SH} state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     rd_bank;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     end_idx;
  logic              cur_full;    // bank being read is a full one (not the closing partial)
  logic              last_word;   // word currently shifting is the bank's last
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     pend;
  logic              part_pend;
  logic [AW-1:0]     last_lat;
  logic              overflow;
  logic [FCNT_W-1:0] frame_cnt;
  logic              sending;

  logic re, sl_time, sl_ch, sel, shift, deq_full, deq_part;
  logic run, have_work, enq_full, lidx_clamp;

  assign run       = !bus.ser_stall;
  assign have_work = (pend != '0) || part_pend;
  // A full bank is dropped when every bank is already waiting.
  assign enq_full  = bus.bank_full && (pend != PEND_MAX);
  assign lidx_clamp = (32'(bus.last_idx) >= 32'(DEPTH));

  always_comb begin
    state_nx = state;
    re       = 1'b0;
    sl_time  = 1'b0;
    sl_ch    = 1'b0;
    sel      = 1'b0;
    shift    = 1'b0;
    deq_full = 1'b0;
    deq_part = 1'b0;
    case (state)
      IDLE:     if (have_work) state_nx = TS_LD;
      TS_LD: begin
        sl_time  = 1'b1;
        state_nx = TS_SH;
      end
      TS_SH: begin
        shift = 1'b1;
        if (cnt == TS_LAST) state_nx = BANK_SEL;
      end
      BANK_SEL: begin
        // Full banks go first so a same-cycle full+partial pair reads in order.
        // re here reads word 0 of the selected bank for the following W_LD.
        if (pend != '0) begin
          deq_full = 1'b1;
          re       = 1'b1;
          state_nx = W_LD;
        end else if (part_pend) begin
          deq_part = 1'b1;
          re       = 1'b1;
          state_nx = W_LD;
        end
      end
      W_LD: begin
        sl_ch    = 1'b1;
        sel      = 1'b1;
        state_nx = W_SH;
      end
      W_SH: begin
        shift = 1'b1;
        sel   = 1'b1;
        if (cnt == WS_LAST) begin
          if (!last_word) begin
            re       = 1'b1;   // idx already points at the next word
            state_nx = W_LD;
          end else if (cur_full) begin
            state_nx = BANK_SEL;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default:  state_nx = IDLE;
    endcase
    if (bus.ser_stall) begin
      state_nx = state;
      re       = 1'b0;
      sl_time  = 1'b0;
      sl_ch    = 1'b0;
      shift    = 1'b0;
      deq_full = 1'b0;
      deq_part = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Sequencer datapath: counters and addresses only move while the sink is ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank   <= '0;
      idx       <= '0;
      end_idx   <= '0;
      cur_full  <= 1'b0;
      last_word <= 1'b0;
      cnt       <= '0;
      frame_cnt <= '0;
      sending   <= 1'b0;
    end else if (run) begin
      case (state)
        IDLE:  if (have_work) sending <= 1'b1;
        TS_LD: cnt <= '0;
        TS_SH: begin
          if (cnt == TS_LAST) idx <= '0;
          else                cnt <= cnt + 1'b1;
        end
        BANK_SEL: begin
          if (deq_full) begin
            end_idx  <= LAST_ADDR;
            cur_full <= 1'b1;
          end else if (deq_part) begin
            end_idx  <= last_lat;
            cur_full <= 1'b0;
          end
        end
        W_LD: begin
          cnt       <= '0;
          last_word <= (idx == end_idx);
          // Stop at end so addr_out never leaves 0..end.
          if (idx != end_idx) idx <= idx + 1'b1;
        end
        W_SH: begin
          if (cnt != WS_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (last_word) begin
            idx     <= '0;
            rd_bank <= (rd_bank == BANK_LAST) ? '0 : rd_bank + 1'b1;
            if (!cur_full) begin
              frame_cnt <= frame_cnt + 1'b1;
              sending   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pending-bank queue runs regardless of ser_stall so no acquisition event is missed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      part_pend <= 1'b0;
      last_lat  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (enq_full && !deq_full)      pend <= pend + 1'b1;
      else if (!enq_full && deq_full) pend <= pend - 1'b1;

      if (bus.mem_done && !part_pend) begin
        part_pend <= 1'b1;
        last_lat  <= lidx_clamp ? LAST_ADDR : bus.last_idx;
      end else if (deq_part) begin
        part_pend <= 1'b0;
      end

      if ((bus.bank_full && (pend == PEND_MAX)) || (bus.mem_done && part_pend))
        overflow <= 1'b1;
    end
  end

  assign bus.addr_out       = {rd_bank, idx};
  assign bus.re             = re;
  assign bus.SL_time        = sl_time;
  assign bus.SL_ch          = sl_ch;
  assign bus.selection_bit  = sel;
  assign bus.serial_readout = shift;
  assign bus.sending_data   = sending;
  assign bus.overflow       = overflow;
  assign bus.frame_cnt      = frame_cnt;
endmodule
